// File: rtl/char_pkg.sv
// Shared types for the character motion blocks: vertical jump state and velocity width.
package char_pkg;
  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } jump_state_t;

  localparam int VEL_W = 6;
endpackage

// File: rtl/frame_tick_detect.sv
// Registered rising-edge detector on the frame strobe: one Clk-wide tick per frame_clk rise.
module frame_tick_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);
  logic fc_dly_q, tick_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc_dly_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      fc_dly_q <= frame_clk;
      tick_q   <= frame_clk & ~fc_dly_q;
    end
  end

  assign tick = tick_q;
endmodule

// File: rtl/character_jump_ctrl.sv
// Vertical-motion sequencer: jump key + collision flags -> signed per-frame Y velocity
// via GROUND/RISE/FALL with gravity, terminal fall speed and a jump buffer.
module character_jump_ctrl
  import char_pkg::*;
#(
  parameter int JUMP_V0       = 6,
  parameter int GRAVITY_DIV   = 4,
  parameter int MAX_FALL      = 6,
  parameter int BUFFER_FRAMES = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       w_key,
  input  logic       ground_contact,
  input  logic       ceiling_contact,
  output logic [9:0] Y_Motion,
  output logic [1:0] jump_state,
  output logic       airborne
);
  localparam logic signed [VEL_W-1:0] VEL_ONE  = VEL_W'(1);
  localparam logic signed [VEL_W-1:0] VEL_JUMP = VEL_W'(-JUMP_V0);
  localparam logic signed [VEL_W-1:0] VEL_MAX  = VEL_W'(MAX_FALL);
  localparam logic [3:0]              GCNT_TOP = 4'(GRAVITY_DIV - 1);
  localparam logic [3:0]              BUF_LOAD = 4'(BUFFER_FRAMES);

  logic                    tick;
  jump_state_t             state_q, state_d;
  logic signed [VEL_W-1:0] vel_q, vel_d, vel_inc;
  logic [3:0]              gcnt_q, gcnt_d, gcnt_step;
  logic [3:0]              jbuf_q, jbuf_d;
  logic                    w_prev_q;
  logic                    press, jump_req, grav_due;

  frame_tick_detect u_tick (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_clk(frame_clk),
    .tick     (tick)
  );

  assign press     = w_key & ~w_prev_q;
  assign jump_req  = press | (jbuf_q != 4'd0);
  assign grav_due  = (gcnt_q == GCNT_TOP);
  assign gcnt_step = grav_due ? 4'd0 : gcnt_q + 4'd1;
  assign vel_inc   = vel_q + VEL_ONE;

  always_comb begin
    state_d = state_q;
    vel_d   = vel_q;
    gcnt_d  = gcnt_q;
    // Airborne presses re-arm the buffer; takeoff and landing clear it below.
    if (press && state_q != GROUND) jbuf_d = BUF_LOAD;
    else if (jbuf_q != 4'd0)        jbuf_d = jbuf_q - 4'd1;
    else                            jbuf_d = 4'd0;

    case (state_q)
      GROUND: begin
        if (!ground_contact) begin
          state_d = FALL;
          vel_d   = '0;
          gcnt_d  = '0;
        end else if (jump_req) begin
          state_d = RISE;
          vel_d   = VEL_JUMP;
          gcnt_d  = '0;
          jbuf_d  = '0;
        end
      end
      RISE: begin
        if (ceiling_contact) begin
          state_d = FALL;
          vel_d   = '0;
          gcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_step;
          if (grav_due) begin
            vel_d = vel_inc;
            if (vel_inc == '0) state_d = FALL;
          end
        end
      end
      FALL: begin
        if (ground_contact) begin
          gcnt_d = '0;
          jbuf_d = '0;
          if (jump_req) begin
            state_d = RISE;
            vel_d   = VEL_JUMP;
          end else begin
            state_d = GROUND;
            vel_d   = '0;
          end
        end else begin
          gcnt_d = gcnt_step;
          if (grav_due && vel_q < VEL_MAX) vel_d = vel_inc;
        end
      end
      default: begin
        state_d = GROUND;
        vel_d   = '0;
        gcnt_d  = '0;
        jbuf_d  = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= GROUND;
      vel_q    <= '0;
      gcnt_q   <= '0;
      jbuf_q   <= '0;
      w_prev_q <= 1'b0;
    end else if (tick) begin
      state_q  <= state_d;
      vel_q    <= vel_d;
      gcnt_q   <= gcnt_d;
      jbuf_q   <= jbuf_d;
      w_prev_q <= w_key;
    end
  end

  assign Y_Motion   = {{(10 - VEL_W){vel_q[VEL_W-1]}}, vel_q};
  assign jump_state = state_q;
  assign airborne   = (state_q != GROUND);
endmodule

// File: tb/tb_character_jump_ctrl.sv
// Bench for character_jump_ctrl: phase-based velocity model checked every cycle, plus literal pins.
module tb_character_jump_ctrl;
  localparam int V0 = 6, GD = 4, MX = 6, BF = 5;

  logic       Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0;
  logic       w_key = 1'b0, ground_contact = 1'b1, ceiling_contact = 1'b0;
  logic [9:0] Y_Motion;
  logic [1:0] jump_state;
  logic       airborne;

  character_jump_ctrl #(
    .JUMP_V0(V0), .GRAVITY_DIV(GD), .MAX_FALL(MX), .BUFFER_FRAMES(BF)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .frame_clk      (frame_clk),
    .w_key          (w_key),
    .ground_contact (ground_contact),
    .ceiling_contact(ceiling_contact),
    .Y_Motion       (Y_Motion),
    .jump_state     (jump_state),
    .airborne       (airborne)
  );

  always #10 Clk = ~Clk;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an airborne phase starts at speed v0 and gains 1 px/frame every GD ticks,
  // capped at MX; the state is RISE while the speed is negative.
  bit m_air, m_prev, m_fcd, m_tick;
  int m_v0, m_n, m_vel, m_t, m_last;

  task automatic model_tick();
    bit press, armed, rising;
    m_t++;
    press  = w_key && !m_prev;
    m_prev = w_key;
    armed  = (m_t - m_last) <= BF;
    if (!m_air) begin
      if (!ground_contact) begin
        m_air = 1; m_v0 = 0; m_n = 0;
      end else if (press) begin
        m_air = 1; m_v0 = -V0; m_n = 0; m_last = -1000;
      end
    end else begin
      rising = (m_vel < 0);
      if (press) m_last = m_t;
      if (rising && ceiling_contact) begin
        m_v0 = 0; m_n = 0;
      end else if (!rising && ground_contact) begin
        if (press || armed) begin m_v0 = -V0; m_n = 0; end
        else m_air = 0;
        m_last = -1000;
      end else m_n++;
    end
    m_vel = !m_air ? 0 : ((m_v0 + m_n / GD > MX) ? MX : m_v0 + m_n / GD);
  endtask

  always @(posedge Clk) begin
    if (Reset) begin
      m_air = 0; m_prev = 0; m_fcd = 0; m_tick = 0;
      m_v0 = 0; m_n = 0; m_vel = 0; m_last = -1000;
    end else begin
      if (m_tick) model_tick();
      m_tick = frame_clk & ~m_fcd;
      m_fcd  = frame_clk;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      logic [9:0] ey;
      logic [1:0] ejs;
      ey  = 10'(m_vel);
      ejs = !m_air ? 2'd0 : (m_vel < 0 ? 2'd1 : 2'd2);
      check("model_y", 32'(Y_Motion), 32'(ey));
      check("model_state", 32'(jump_state), 32'(ejs));
      check("model_air", 32'(airborne), 32'(m_air));
    end
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      repeat (2) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
    end
  endtask

  task automatic lit(input string name, input logic [9:0] y, input logic [1:0] js);
    check({name, "_y"}, 32'(Y_Motion), 32'(y));
    check({name, "_state"}, 32'(jump_state), 32'(js));
    check({name, "_air"}, 32'(airborne), 32'(js != 2'd0));
  endtask

  task automatic takeoff();
    w_key = 1'b1; ticks(1);
    w_key = 1'b0; ground_contact = 1'b0;
  endtask

  initial begin
    @(negedge Clk);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    chk_en = 1'b1;
    lit("reset", 10'h000, 2'd0);
    ticks(100);
    lit("idle", 10'h000, 2'd0);

    // Basic jump arc and terminal velocity
    takeoff();       lit("jump_v0", 10'h3FA, 2'd1);
    ticks(4);        lit("jump_4", 10'h3FB, 2'd1);
    ticks(20);       lit("apex", 10'h000, 2'd2);
    ticks(24);       lit("term", 10'h006, 2'd2);
    ticks(50);       lit("term_hold", 10'h006, 2'd2);
    ground_contact = 1'b1; ticks(1); lit("land", 10'h000, 2'd0);

    // Ceiling beats simultaneous ground contact
    takeoff(); ticks(8); lit("rise_m4", 10'h3FC, 2'd1);
    ceiling_contact = 1'b1; ground_contact = 1'b1; ticks(1);
    lit("ceiling", 10'h000, 2'd2);
    ceiling_contact = 1'b0; ticks(1); lit("ceil_land", 10'h000, 2'd0);

    // Jump buffer: 3 ticks early re-jumps, 6 ticks early does not
    takeoff(); ticks(30);
    w_key = 1'b1; ticks(1); w_key = 1'b0; ticks(2);
    ground_contact = 1'b1; ticks(1); ground_contact = 1'b0;
    lit("buf_hit", 10'h3FA, 2'd1);
    ticks(30);
    w_key = 1'b1; ticks(1); w_key = 1'b0; ticks(5);
    ground_contact = 1'b1; ticks(1);
    lit("buf_miss", 10'h000, 2'd0);

    // Held key does not retrigger on landing
    w_key = 1'b1; ticks(1); ground_contact = 1'b0; ticks(30);
    ground_contact = 1'b1; ticks(1); lit("hold_land", 10'h000, 2'd0);
    ticks(2); lit("hold_stay", 10'h000, 2'd0);
    w_key = 1'b0; ticks(1);

    // Reset mid-rise
    takeoff(); ticks(3);
    Reset = 1'b1; @(negedge Clk);
    lit("mid_reset", 10'h000, 2'd0);
    Reset = 1'b0; ground_contact = 1'b1;
    repeat (2) @(negedge Clk);

    // frame_clk held high gives a single update (gcnt 3 -> one velocity step)
    takeoff(); ticks(3);
    frame_clk = 1'b1; repeat (40) @(negedge Clk);
    frame_clk = 1'b0; repeat (4) @(negedge Clk);
    lit("fc_hold", 10'h3FB, 2'd1);
    ticks(30);
    ground_contact = 1'b1; ticks(1); lit("land2", 10'h000, 2'd0);

    // Walk-off has priority over a press
    ground_contact = 1'b0; w_key = 1'b1; ticks(1);
    lit("walkoff", 10'h000, 2'd2);
    w_key = 1'b0; ticks(10);
    ground_contact = 1'b1; ticks(2);
    lit("final", 10'h000, 2'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/character_jump_ctrl.md
Name: character_jump_ctrl

Overview:
Vertical-motion sequencer for a player character (Fireboy, and later Watergirl from a second instance). Converts the jump key plus collision flags into a signed per-frame Y velocity using a GROUND/RISE/FALL state machine with gravity, a terminal fall speed and jump buffering. Its Y_Motion output drives the character's Y position-update path in place of the constant-zero Y motion used today. ground_contact and ceiling_contact come from the tile-collision logic.

Parameters:
JUMP_V0, 6, initial upward speed in px/frame; range 1..15
GRAVITY_DIV, 4, frame ticks per +1 px/frame velocity increment; range 1..15
MAX_FALL, 6, terminal downward speed in px/frame; range 1..15
BUFFER_FRAMES, 5, frames a jump press stays armed while airborne; range 0..15

Ports:
Clk  input  1  50 MHz system clock
Reset  input  1  synchronous, active-high reset
frame_clk  input  1  frame strobe (~60 Hz), asynchronous to the frame phase
w_key  input  1  jump key, level
ground_contact  input  1  character's feet rest on a solid tile
ceiling_contact  input  1  character's head touches a solid tile
Y_Motion  output  10  signed two's-complement px/frame; negative = up
jump_state  output  2  current state: 0 GROUND, 1 RISE, 2 FALL
airborne  output  1  high in RISE or FALL

Behaviour:
- Clock and reset: single clock Clk. Reset is synchronous and active-high.
- Reset values: state GROUND, vel 0, gcnt 0, buf 0, w_prev 0, frame_clk_delayed 0, tick 0. Outputs: Y_Motion 0, jump_state 0, airborne 0.
- Tick generation:
  - frame_clk_delayed <= frame_clk.
  - tick <= frame_clk & ~frame_clk_delayed (registered).
  - All state updates happen only on a Clk edge where tick==1. Outputs are registered and change on that same edge.
- Jump press: press = w_key & ~w_prev, sampled on tick. w_prev <= w_key on every tick. Holding the key never retriggers a jump; the key must be released and pressed again.
- Velocity register: vel, 6-bit signed. Y_Motion is vel sign-extended to 10 bits.
- GROUND (vel 0, gcnt 0):
  - If ~ground_contact: go to FALL, vel=0, gcnt=0. Walk-off has priority over a press.
  - Else if press, or buf>0: go to RISE, vel=-JUMP_V0, gcnt=0, buf=0.
- RISE:
  - If ceiling_contact: go to FALL, vel=0, gcnt=0. Ceiling has priority over everything, including a simultaneous ground_contact.
  - Else gcnt++. When gcnt reaches GRAVITY_DIV-1: vel++, gcnt=0. If the new vel==0, go to FALL on that same tick.
- FALL:
  - If ground_contact: vel=0, gcnt=0. Then go to RISE with vel=-JUMP_V0 and buf=0 if press or buf>0; otherwise go to GROUND with buf=0.
  - Else apply gravity as in RISE, saturating vel at +MAX_FALL. gcnt keeps cycling after saturation.
- Jump buffer:
  - A press while in RISE or FALL loads buf=BUFFER_FRAMES.
  - Otherwise buf decrements on each tick while nonzero; it never wraps below 0.
  - BUFFER_FRAMES=0 disables buffering.
- jump_state and airborne reflect the registered state.
- Reset mid-jump: the next edge forces the reset values regardless of tick.
- A frame_clk held high produces exactly one tick.

Decomposition:
- Shared package char_pkg:
  - enum jump_state_t {GROUND=0, RISE=1, FALL=2}, 2 bits.
  - localparam VEL_W=6.
- One sub-module: frame_tick_detect (Clk, Reset, frame_clk -> tick), containing the registered rising-edge detector. The sprite modules will reuse it.

Test Plan:
- Reset, then ground_contact=1 with 100 ticks idle -> Y_Motion=0, jump_state=0, airborne=0 throughout.
- Press w_key for 1 tick with defaults, ground_contact=1 -> Y_Motion=-6 (10'h3FA). Then -5 after 4 more ticks, and each step thereafter every 4 ticks. After 24 ticks vel=0 and jump_state=2.
- Continue falling with ground_contact=0 -> vel steps +1 every 4 ticks, reaches +6 after 24 ticks and stays at +6 for 50 further ticks.
- During RISE at vel=-4, assert ceiling_contact and ground_contact together for 1 tick -> jump_state=2, Y_Motion=0. Next tick with ground_contact=1 -> jump_state=0.
- In FALL, press w_key 3 ticks before ground_contact rises -> landing tick gives jump_state=1, Y_Motion=-6. Repeat with the press 6 ticks early -> jump_state=0, Y_Motion=0.
- Hold w_key high across landing -> no second jump. Also assert Reset during RISE -> next edge gives Y_Motion=0 and jump_state=0. Also keep frame_clk high for 10 frames' worth of cycles -> exactly one update.
